// File: rtl/sd_sector_reader.sv
// sd_sector_reader: one-sector cached byte reader in front of the SD sector bridge
module sd_sector_reader #(
   parameter logic [23:0] TIMEOUT   = 24'd10_000_000,
   parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        rd_err,
   output logic        busy,
   input  logic        img_mounted,
   input  logic [31:0] img_size,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [31:0] sd_lba,
   output logic [7:0]  sd_buff_din,
   input  logic        sd_ack,
   input  logic [13:0] sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   input  logic        sd_buff_wr
);
   typedef enum logic [2:0] {IDLE, CHECK, REQ, XFER, FETCH, DONE} state_t;
   state_t      state;
   logic [31:0] addr;
   logic [22:0] tag;
   logic        valid;
   logic        dirty;
   logic        ack_q;
   logic        mount_q;
   logic [23:0] cnt;
   logic [7:0]  mem [512];
   logic [7:0]  ram_q;
   logic        kill;
   logic        oor;
   logic        hit;
   logic        unused_ok;
   assign sd_wr       = 1'b0;
   assign sd_buff_din = 8'h00;
   assign unused_ok   = ^sd_buff_addr[13:9];
   assign kill = !img_mounted || !mount_q;
   assign oor  = !img_mounted || (addr >= img_size);
   assign hit  = valid && !kill && (tag == addr[31:9]);
   // Sector buffer: captures streamed bytes only during a transfer; read port follows the latched address
   always_ff @(posedge clk) begin
      if (state == XFER && sd_buff_wr)
         mem[sd_buff_addr[8:0]] <= sd_buff_dout;
      ram_q <= mem[addr[8:0]];
   end
   // Request FSM with cache tag/valid; an unmount or remount edge always invalidates the cache
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         addr     <= 32'h0;
         tag      <= 23'h0;
         valid    <= 1'b0;
         dirty    <= 1'b0;
         ack_q    <= 1'b0;
         mount_q  <= 1'b0;
         cnt      <= 24'h0;
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         busy     <= 1'b0;
         sd_rd    <= 1'b0;
         sd_lba   <= 32'h0;
      end else begin
         ack_q    <= sd_ack;
         mount_q  <= img_mounted;
         rd_valid <= 1'b0;
         case (state)
            IDLE: if (rd_req) begin
               addr  <= rd_addr;
               busy  <= 1'b1;
               state <= CHECK;
            end
            CHECK: if (oor) begin
               rd_data  <= FILL_BYTE;
               rd_err   <= 1'b1;
               rd_valid <= 1'b1;
               state    <= DONE;
            end else if (hit) begin
               state <= FETCH;
            end else begin
               valid  <= 1'b0;
               dirty  <= 1'b0;
               sd_lba <= {9'b0, addr[31:9]};
               sd_rd  <= 1'b1;
               cnt    <= 24'h0;
               state  <= REQ;
            end
            REQ: if (sd_ack) begin
               sd_rd <= 1'b0;
               state <= XFER;
            end else if (cnt == TIMEOUT - 24'd1) begin
               sd_rd    <= 1'b0;
               rd_err   <= 1'b1;
               rd_data  <= FILL_BYTE;
               rd_valid <= 1'b1;
               state    <= DONE;
            end else begin
               cnt <= cnt + 24'd1;
            end
            XFER: if (ack_q && !sd_ack) begin
               tag   <= addr[31:9];
               valid <= !dirty;
               state <= FETCH;
            end
            FETCH: begin
               rd_data  <= ram_q;
               rd_err   <= 1'b0;
               rd_valid <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               busy   <= 1'b0;
               rd_err <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (kill) begin
            valid <= 1'b0;
            dirty <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sd_sector_reader.sv
// tb_sd_sector_reader: scoreboard bench for the cached SD sector reader
module tb_sd_sector_reader;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rd_req = 1'b0;
   logic [31:0] rd_addr = 32'h0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_err;
   logic        busy;
   logic        img_mounted = 1'b0;
   logic [31:0] img_size = 32'h0;
   logic        sd_rd;
   logic        sd_wr;
   logic [31:0] sd_lba;
   logic [7:0]  sd_buff_din;
   logic        sd_ack = 1'b0;
   logic [13:0] sd_buff_addr = 14'h0;
   logic [7:0]  sd_buff_dout = 8'h0;
   logic        sd_buff_wr = 1'b0;
   int nchk = 0, nerr = 0, nvalid = 0, mark = 0;
   int cyc = 0, req_cyc = 0, valid_cyc = 0, rd_hi = 0, r0 = 0, n0 = 0;
   logic [8:0] exp_q [$];
   logic [8:0] e;

   sd_sector_reader #(.TIMEOUT(24'd16), .FILL_BYTE(8'hFF)) dut (
      .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .busy(busy),
      .img_mounted(img_mounted), .img_size(img_size), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_lba(sd_lba), .sd_buff_din(sd_buff_din), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sd_rd) rd_hi++;
      if (rd_valid) begin
         nvalid++;
         valid_cyc = cyc;
         if (exp_q.size() == 0) chk("unexp_valid", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("rd_data", {24'h0, rd_data}, {24'h0, e[7:0]});
            chk("rd_err", {31'h0, rd_err}, {31'h0, e[8]});
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic err, input logic [7:0] d, input logic push);
      @(posedge clk); #1;
      if (push) exp_q.push_back({err, d});
      rd_req = 1'b1;
      rd_addr = a;
      req_cyc = cyc;
      mark = nvalid;
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic wait_valid(input int max);
      int k = 0;
      while (nvalid == mark && k < max) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("valid_seen", {31'h0, nvalid > mark}, 1);
      chk("busy_fall", {31'h0, busy}, 0);
   endtask

   task automatic wait_sd_rd();
      int k = 0;
      while (!sd_rd && k < 200) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic bridge(input logic [31:0] lba, input logic [7:0] key);
      wait_sd_rd();
      chk("sd_rd_seen", {31'h0, sd_rd}, 1);
      chk("sd_lba", sd_lba, lba);
      @(posedge clk); #1 sd_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("sd_rd_drop", {31'h0, sd_rd}, 0);
      for (int i = 0; i < 512; i++) begin
         @(posedge clk); #1;
         sd_buff_wr = 1'b1;
         sd_buff_addr = 14'(i);
         sd_buff_dout = 8'(i) ^ key;
      end
      @(posedge clk); #1 sd_buff_wr = 1'b0;
      @(posedge clk); #1 sd_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst_valid", {31'h0, rd_valid}, 0);
      chk("rst_err", {31'h0, rd_err}, 0);
      chk("rst_data", {24'h0, rd_data}, 0);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_sd_rd", {31'h0, sd_rd}, 0);
      chk("rst_lba", sd_lba, 0);
      @(posedge clk); #1 reset_n = 1'b1;
      img_mounted = 1'b1;
      img_size = 32'd4096;
      repeat (3) @(posedge clk);
      // miss on sector 1
      issue(32'h205, 1'b0, 8'h5F, 1'b1);
      bridge(32'd1, 8'h5A);
      wait_valid(20);
      // hit in same sector
      r0 = rd_hi;
      issue(32'h3FF, 1'b0, 8'hA5, 1'b1);
      wait_valid(20);
      chk("hit_lat", valid_cyc - req_cyc, 3);
      chk("hit_no_sd_rd", rd_hi - r0, 0);
      // stray buffer write outside a transfer must not corrupt the cache
      @(posedge clk); #1 sd_buff_wr = 1'b1; sd_buff_addr = 14'h5; sd_buff_dout = 8'h00;
      @(posedge clk); #1 sd_buff_wr = 1'b0;
      issue(32'h205, 1'b0, 8'h5F, 1'b1);
      wait_valid(20);
      chk("stray_lat", valid_cyc - req_cyc, 3);
      // out of range and unmounted
      r0 = rd_hi;
      issue(32'd4096, 1'b1, 8'hFF, 1'b1);
      wait_valid(20);
      chk("oor_lat", valid_cyc - req_cyc, 2);
      img_mounted = 1'b0;
      issue(32'h0, 1'b1, 8'hFF, 1'b1);
      wait_valid(20);
      chk("unmnt_lat", valid_cyc - req_cyc, 2);
      chk("err_no_sd_rd", rd_hi - r0, 0);
      img_mounted = 1'b1;
      repeat (2) @(posedge clk);
      // timeout with silent bridge
      r0 = rd_hi;
      issue(32'h400, 1'b1, 8'hFF, 1'b1);
      wait_valid(100);
      chk("timeout_sd_rd_len", rd_hi - r0, 16);
      // refill sector 1, confirm it is cached
      issue(32'h205, 1'b0, 8'h5F, 1'b1);
      bridge(32'd1, 8'h5A);
      wait_valid(20);
      issue(32'h3FF, 1'b0, 8'hA5, 1'b1);
      wait_valid(20);
      chk("hit2_lat", valid_cyc - req_cyc, 3);
      // remount pulse invalidates; second request during transfer ignored
      @(posedge clk); #1 img_mounted = 1'b0;
      @(posedge clk); #1 img_mounted = 1'b1;
      issue(32'h200, 1'b0, 8'h3C, 1'b1);
      fork
         bridge(32'd1, 8'h3C);
         begin
            repeat (20) @(posedge clk);
            #1 rd_req = 1'b1; rd_addr = 32'h0;
            @(posedge clk); #1 rd_req = 1'b0;
         end
      join
      wait_valid(20);
      n0 = nvalid;
      repeat (10) @(posedge clk);
      chk("single_valid", nvalid, n0);
      chk("queue_empty", exp_q.size(), 0);
      issue(32'h3FF, 1'b0, 8'hC3, 1'b1);
      wait_valid(20);
      chk("recache_lat", valid_cyc - req_cyc, 3);
      // async reset in the middle of a transfer
      issue(32'h605, 1'b0, 8'h00, 1'b0);
      wait_sd_rd();
      chk("rst_case_lba", sd_lba, 3);
      @(posedge clk); #1 sd_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         sd_buff_wr = 1'b1;
         sd_buff_addr = 14'(i);
         sd_buff_dout = 8'h11;
      end
      chk("xfer_busy", {31'h0, busy}, 1);
      @(posedge clk); #1 reset_n = 1'b0;
      #1;
      chk("async_sd_rd", {31'h0, sd_rd}, 0);
      chk("async_busy", {31'h0, busy}, 0);
      chk("async_valid", {31'h0, rd_valid}, 0);
      chk("async_lba", sd_lba, 0);
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      issue(32'h205, 1'b0, 8'h5F, 1'b1);
      bridge(32'd1, 8'h5A);
      wait_valid(20);
      chk("sd_wr_const", {31'h0, sd_wr}, 0);
      chk("din_const", {24'h0, sd_buff_din}, 0);
      chk("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
